// File: rtl/fifo_arb_pkg.sv
// Shared types and elaboration helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Smallest w >= 1 with 2**w >= n.
    function automatic int unsigned id_width(input int unsigned n);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 31; i++) begin
            if ((32'd1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

    function automatic bit params_ok(input int unsigned nreq, input int unsigned burst);
        return (nreq >= 1) && (nreq <= 16) && (burst >= 1);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin pick: first set request scanning from ptr upward, modulo NREQ.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            any,
    output logic [IDW-1:0]  sel
);
    logic [NREQ-1:0] rot;
    logic [IDW-1:0]  off;
    logic [IDW:0]    sum;

    assign any = |req;

    // Rotate so ptr lands at bit 0, priority-encode, then rotate the index back.
    always_comb begin
        rot = NREQ'({req, req} >> ptr);
        off = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (rot[i]) off = IDW'(i);
        end
        sum = (IDW + 1)'(ptr) + (IDW + 1)'(off);
        if (sum >= (IDW + 1)'(NREQ)) sum = sum - (IDW + 1)'(NREQ);
        sel = sum[IDW-1:0];
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NREQ requesters.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned DSIZE = 8,
    parameter int unsigned BURST = 4,
    parameter int unsigned IDW   = id_width(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*DSIZE-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  fifo_wfull,
    output logic                  fifo_wreq,
    output logic [DSIZE-1:0]      fifo_wdata,
    output logic                  gnt_valid,
    output logic [IDW-1:0]        gnt_id
);
    localparam int unsigned CW = id_width(BURST);

    if (!params_ok(NREQ, BURST)) begin : g_bad_params
        $error("fifo_wr_arbiter: NREQ must be 1..16 and BURST >= 1");
    end

    arb_state_e     st_q, st_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           pick_any;
    logic [IDW-1:0] pick_sel;
    logic           owner_valid;
    logic           release_grant;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req (req_valid),
        .ptr (ptr_q),
        .any (pick_any),
        .sel (pick_sel)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            st_q    <= st_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        st_d          = st_q;
        owner_d       = owner_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        req_ready     = '0;
        fifo_wreq     = 1'b0;
        fifo_wdata    = '0;
        gnt_valid     = 1'b0;
        gnt_id        = '0;
        release_grant = 1'b0;
        owner_valid   = req_valid[owner_q];

        case (st_q)
            ST_IDLE: begin
                if (pick_any) begin
                    owner_d = pick_sel;
                    cnt_d   = '0;
                    st_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                gnt_valid          = 1'b1;
                gnt_id             = owner_q;
                req_ready[owner_q] = ~fifo_wfull;
                fifo_wreq          = owner_valid & ~fifo_wfull;
                fifo_wdata         = req_data[int'(owner_q) * int'(DSIZE) +: DSIZE];
                // A full FIFO with the owner still valid is a stall, not a release.
                if (fifo_wreq) begin
                    if (cnt_q == CW'(BURST - 1)) release_grant = 1'b1;
                    else                         cnt_d = CW'(cnt_q + CW'(1));
                end else if (!owner_valid) begin
                    release_grant = 1'b1;
                end
                if (release_grant) begin
                    st_d  = ST_IDLE;
                    cnt_d = '0;
                    ptr_d = (owner_q == IDW'(NREQ - 1)) ? '0 : IDW'(owner_q + IDW'(1));
                end
            end
            default: st_d = ST_IDLE;
        endcase

        // Outputs are quiet during reset so no beat escapes a mid-burst reset.
        if (rst) begin
            req_ready  = '0;
            fifo_wreq  = 1'b0;
            fifo_wdata = '0;
            gnt_valid  = 1'b0;
            gnt_id     = '0;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: NREQ=4/BURST=4 instance plus NREQ=3/BURST=1 wrap instance.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    int          checks = 0;
    int          errors = 0;

    logic        rst;
    logic [3:0]  rv;
    logic [31:0] rd;
    logic        wfull;
    logic [3:0]  rr;
    logic        wreq;
    logic [7:0]  wd;
    logic        gv;
    logic [1:0]  gid;

    logic        rst3;
    logic [2:0]  rv3;
    logic [23:0] rd3;
    logic        wfull3;
    logic [2:0]  rr3;
    logic        wreq3;
    logic [7:0]  wd3;
    logic        gv3;
    logic [1:0]  gid3;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NREQ(4), .DSIZE(8), .BURST(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (rv),
        .req_data   (rd),
        .req_ready  (rr),
        .fifo_wfull (wfull),
        .fifo_wreq  (wreq),
        .fifo_wdata (wd),
        .gnt_valid  (gv),
        .gnt_id     (gid)
    );

    fifo_wr_arbiter #(.NREQ(3), .DSIZE(8), .BURST(1)) dut3 (
        .clk        (clk),
        .rst        (rst3),
        .req_valid  (rv3),
        .req_data   (rd3),
        .req_ready  (rr3),
        .fifo_wfull (wfull3),
        .fifo_wreq  (wreq3),
        .fifo_wdata (wd3),
        .gnt_valid  (gv3),
        .gnt_id     (gid3)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; rv = '0; wfull = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rv = 4'hF; rd = 32'h33221100; wfull = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1; checks++;
            if ({gv, gid, wreq, rr, wd} !== 16'h0) begin
                errors++; $display("FAIL reset_hold[%0d] got %h exp 0000", i, {gv, gid, wreq, rr, wd});
            end
            cyc();
        end
        rst = 1'b0;
        #1; checks++;
        if ({gv, gid, wreq, rr, wd} !== 16'h0) begin
            errors++; $display("FAIL reset_idle got %h exp 0000", {gv, gid, wreq, rr, wd});
        end
        cyc();
        #1; checks++;
        if ({gv, gid, wreq, rr, wd} !== {1'b1, 2'd0, 1'b1, 4'b0001, 8'h00}) begin
            errors++; $display("FAIL reset_first_grant got %h exp %h", {gv, gid, wreq, rr, wd},
                               {1'b1, 2'd0, 1'b1, 4'b0001, 8'h00});
        end
        cyc();
    endtask

    task automatic test_round_robin();
        int       sent [4];
        logic       exp_gv;
        logic [1:0] exp_id;
        logic [7:0] exp_d;
        do_reset();
        for (int i = 0; i < 4; i++) sent[i] = 0;
        rv = 4'hF;
        for (int c = 0; c < 25; c++) begin
            for (int i = 0; i < 4; i++) rd[i*8 +: 8] = 8'(i * 16 + (sent[i] % 4));
            #1;
            exp_gv = (c % 5) != 0;
            exp_id = exp_gv ? 2'((c / 5) % 4) : 2'd0;
            exp_d  = exp_gv ? 8'(((c / 5) % 4) * 16 + (c % 5) - 1) : 8'h00;
            checks++;
            if ({gv, wreq, gid, wd} !== {exp_gv, exp_gv, exp_id, exp_d}) begin
                errors++; $display("FAIL rr_sat[%0d] got gv=%b wreq=%b id=%0d d=%h exp gv=%b id=%0d d=%h",
                                   c, gv, wreq, gid, wd, exp_gv, exp_id, exp_d);
            end
            for (int i = 0; i < 4; i++) if (rr[i] && rv[i]) sent[i]++;
            cyc();
        end
    endtask

    task automatic test_early_release();
        do_reset();
        rv = 4'b0100; rd = 32'h33221100;
        #1; checks++;
        if (gv !== 1'b0) begin errors++; $display("FAIL early_idle got %b exp 0", gv); end
        cyc();
        for (int b = 0; b < 2; b++) begin
            #1; checks++;
            if ({gv, gid, wreq, wd} !== {1'b1, 2'd2, 1'b1, 8'h22}) begin
                errors++; $display("FAIL early_beat[%0d] got %h exp %h", b, {gv, gid, wreq, wd},
                                   {1'b1, 2'd2, 1'b1, 8'h22});
            end
            cyc();
        end
        rv = 4'b0000;
        #1; checks++;
        if ({gv, gid, wreq} !== {1'b1, 2'd2, 1'b0}) begin
            errors++; $display("FAIL early_drop got %b exp %b", {gv, gid, wreq}, {1'b1, 2'd2, 1'b0});
        end
        cyc();
        rv = 4'b1010;
        #1; checks++;
        if (gv !== 1'b0) begin errors++; $display("FAIL early_bubble got %b exp 0", gv); end
        cyc();
        #1; checks++;
        if ({gv, gid, wreq, wd} !== {1'b1, 2'd3, 1'b1, 8'h33}) begin
            errors++; $display("FAIL early_next_owner got %h exp %h", {gv, gid, wreq, wd},
                               {1'b1, 2'd3, 1'b1, 8'h33});
        end
        cyc();
    endtask

    task automatic test_full_stall();
        do_reset();
        rv = 4'b0010; rd = 32'h33221100;
        cyc();
        #1; checks++;
        if ({gv, gid, wreq, rr} !== {1'b1, 2'd1, 1'b1, 4'b0010}) begin
            errors++; $display("FAIL stall_first_beat got %b exp %b", {gv, gid, wreq, rr}, 8'b1011_0010);
        end
        cyc();
        wfull = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1; checks++;
            if ({gv, gid, wreq, rr} !== {1'b1, 2'd1, 1'b0, 4'b0000}) begin
                errors++; $display("FAIL stall_full[%0d] got %b exp %b", i, {gv, gid, wreq, rr}, 8'b1010_0000);
            end
            cyc();
        end
        wfull = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1; checks++;
            if ({gv, gid, wreq, rr, wd} !== {1'b1, 2'd1, 1'b1, 4'b0010, 8'h11}) begin
                errors++; $display("FAIL stall_resume[%0d] got %h exp %h", i, {gv, gid, wreq, rr, wd},
                                   {1'b1, 2'd1, 1'b1, 4'b0010, 8'h11});
            end
            cyc();
        end
        #1; checks++;
        if (gv !== 1'b0) begin errors++; $display("FAIL stall_release got %b exp 0", gv); end
        cyc();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        rv = 4'b0110; rd = 32'h33221100;
        cyc();
        for (int b = 0; b < 2; b++) begin
            #1; checks++;
            if ({gv, gid, wreq, wd} !== {1'b1, 2'd1, 1'b1, 8'h11}) begin
                errors++; $display("FAIL rmb_beat[%0d] got %h exp %h", b, {gv, gid, wreq, wd},
                                   {1'b1, 2'd1, 1'b1, 8'h11});
            end
            cyc();
        end
        rst = 1'b1;
        #1; checks++;
        if ({gv, gid, wreq, rr, wd} !== 16'h0) begin
            errors++; $display("FAIL rmb_rst_cycle got %h exp 0000", {gv, gid, wreq, rr, wd});
        end
        cyc();
        rst = 1'b0; rv = 4'b0111;
        #1; checks++;
        if ({gv, wreq} !== 2'b00) begin errors++; $display("FAIL rmb_idle got %b exp 00", {gv, wreq}); end
        cyc();
        #1; checks++;
        if ({gv, gid, wreq, wd} !== {1'b1, 2'd0, 1'b1, 8'h00}) begin
            errors++; $display("FAIL rmb_regrant got %h exp %h", {gv, gid, wreq, wd}, {1'b1, 2'd0, 1'b1, 8'h00});
        end
        cyc();
    endtask

    task automatic test_wrap_nreq3();
        logic       exp_gv;
        logic [1:0] exp_id;
        logic [7:0] exp_d;
        rst3 = 1'b1; rv3 = 3'b111; rd3 = 24'h221100; wfull3 = 1'b0;
        cyc();
        rst3 = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            exp_gv = (c % 2) == 1;
            exp_id = exp_gv ? 2'((c / 2) % 3) : 2'd0;
            exp_d  = exp_gv ? 8'(((c / 2) % 3) * 8'h11) : 8'h00;
            checks++;
            if ({gv3, gid3, wreq3, wd3} !== {exp_gv, exp_id, exp_gv, exp_d}) begin
                errors++; $display("FAIL wrap3[%0d] got gv=%b id=%0d wreq=%b d=%h exp gv=%b id=%0d d=%h",
                                   c, gv3, gid3, wreq3, wd3, exp_gv, exp_id, exp_d);
            end
            cyc();
        end
    endtask

    initial begin
        rst = 1'b1; rv = 4'hF; rd = 32'h33221100; wfull = 1'b0;
        rst3 = 1'b1; rv3 = '0; rd3 = '0; wfull3 = 1'b0;
        cyc();
        test_reset();
        test_round_robin();
        test_early_release();
        test_full_stall();
        test_reset_mid_burst();
        test_wrap_nreq3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
